// File: rtl/riot_pkg.sv
// riot_pkg: shared types and constants for the RIOT bus master.
package riot_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Target select encoding as presented on req_sel
    typedef enum logic [1:0] {
        SEL_ROM  = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_IO   = 2'd2,
        SEL_RSVD = 2'd3
    } sel_t;

    // Read data returned with an error response
    localparam logic [7:0] ERR_DATA = 8'hFF;

endpackage

// File: rtl/riot_irq_sync.sv
// riot_irq_sync: two-flop synchronizer for the asynchronous irq_n line plus
// a one-cycle pulse on each synchronized falling edge.
module riot_irq_sync (
    input  logic phi2,
    input  logic rst,
    input  logic irq_n,
    output logic irq_fall
);

    // [0],[1] synchronizer stages, [2] previous synchronized value.
    // Reset to 1 so that leaving reset never looks like a falling edge.
    logic [2:0] sync_q;

    // Shift irq_n through the synchronizer and edge-history flop
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], irq_n};
        end
    end

    assign irq_fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/riot_bus_master.sv
// riot_bus_master: single-outstanding request/response master for a RIOT-style
// ROM/RAM/IO peripheral bus. Bus outputs are registered and only leave their
// idle values while a transaction is on the bus.
// Optional interrupt latch enabled by defining RIOT_BUS_MASTER_IRQ_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request, bus idle
// ACCESS | one-cycle address/strobe phase (write strobe asserted here)
// WAIT   | read data phase, waits for OE (RAM/IO) or samples DO (ROM)
// RESP   | response held on rsp_* until rsp_ready
module riot_bus_master
    import riot_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic       phi2,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [1:0] req_sel,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [9:0] A,
    output logic [7:0] DI,
    output logic       we_n,
    output logic       CS1,
    output logic       CS2,
    output logic       RS_n,
    input  logic [7:0] DO,
    input  logic       OE,
    input  logic       irq_n,
    input  logic       irq_ack,
    output logic       irq_pending
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic       we_q;
    sel_t       sel_q;
    logic [9:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;

    // Transaction fields seen by the bus logic: live request while in IDLE
    // (the bus is loaded on the same edge that accepts it), latched afterwards.
    logic       cur_we;
    sel_t       cur_sel;
    logic [9:0] cur_addr;
    logic [7:0] cur_wdata;
    logic [9:0] a_d;
    logic [7:0] di_d;
    logic       we_n_d, cs1_d, cs2_d, rs_n_d;

    // State, counter and response registers
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture the request on acceptance
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            sel_q   <= SEL_ROM;
            addr_q  <= 10'h000;
            wdata_q <= 8'h00;
        end else if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            sel_q   <= sel_t'(req_sel);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Next-state, wait counter and response data
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (sel_t'(req_sel) == SEL_RSVD) begin
                        state_d = RESP;
                        rdata_d = ERR_DATA;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                    rdata_d = 8'h00;
                    err_d   = 1'b0;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 8'h00;
                end
            end
            WAIT: begin
                if (sel_q == SEL_ROM || OE) begin
                    state_d = RESP;
                    rdata_d = DO;
                    err_d   = 1'b0;
                end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
                    state_d = RESP;
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    cnt_d   = 8'h00;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus values for the coming cycle, derived from the next state
    always_comb begin
        cur_we    = (state_q == IDLE) ? req_we           : we_q;
        cur_sel   = (state_q == IDLE) ? sel_t'(req_sel)  : sel_q;
        cur_addr  = (state_q == IDLE) ? req_addr         : addr_q;
        cur_wdata = (state_q == IDLE) ? req_wdata        : wdata_q;
        a_d    = 10'h000;
        di_d   = 8'h00;
        we_n_d = 1'b1;
        cs1_d  = 1'b1;
        cs2_d  = 1'b1;
        rs_n_d = 1'b1;
        if (state_d == ACCESS || state_d == WAIT) begin
            a_d    = cur_addr;
            di_d   = cur_we ? cur_wdata : 8'h00;
            we_n_d = ~(cur_we && state_d == ACCESS);
            if (cur_sel == SEL_ROM) begin
                rs_n_d = 1'b0;
                cs2_d  = 1'b0;
            end else begin
                cs1_d  = 1'b0;
            end
        end
    end

    // Registered bus outputs
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            A    <= 10'h000;
            DI   <= 8'h00;
            we_n <= 1'b1;
            CS1  <= 1'b1;
            CS2  <= 1'b1;
            RS_n <= 1'b1;
        end else begin
            A    <= a_d;
            DI   <= di_d;
            we_n <= we_n_d;
            CS1  <= cs1_d;
            CS2  <= cs2_d;
            RS_n <= rs_n_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

`ifdef RIOT_BUS_MASTER_IRQ_EN
    logic irq_fall;
    logic irq_pend_q;

    riot_irq_sync u_irq_sync (
        .phi2     (phi2),
        .rst      (rst),
        .irq_n    (irq_n),
        .irq_fall (irq_fall)
    );

    // Latch interrupts; a new edge takes priority over a same-cycle ack
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            irq_pend_q <= 1'b0;
        end else if (irq_fall) begin
            irq_pend_q <= 1'b1;
        end else if (irq_ack) begin
            irq_pend_q <= 1'b0;
        end
    end

    assign irq_pending = irq_pend_q;
`else
    logic unused_irq;
    assign unused_irq  = irq_n ^ irq_ack;
    assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_riot_bus_master.sv
// tb_riot_bus_master: directed and randomized transactions against a
// transaction-level reference model (latency, response data, bus pattern).
module tb_riot_bus_master;

    localparam int TO = 8;

    logic       phi2 = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_we;
    logic [1:0] req_sel;
    logic [9:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [9:0] A;
    logic [7:0] DI;
    logic       we_n, CS1, CS2, RS_n;
    logic [7:0] DO;
    logic       OE;
    logic       irq_n, irq_ack, irq_pending;

    int n_checks = 0;
    int n_errors = 0;

    riot_bus_master #(.TIMEOUT(TO)) dut (
        .phi2        (phi2),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_sel     (req_sel),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .A           (A),
        .DI          (DI),
        .we_n        (we_n),
        .CS1         (CS1),
        .CS2         (CS2),
        .RS_n        (RS_n),
        .DO          (DO),
        .OE          (OE),
        .irq_n       (irq_n),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pending)
    );

    always #5 phi2 = ~phi2;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge phi2);
        #1;
    endtask

    // Expected bus pattern: idle, or driven for the given transaction
    task automatic chk_bus(input string tag, input bit active, input bit access,
                           input bit we, input logic [1:0] sel,
                           input logic [9:0] addr, input logic [7:0] wd);
        chk({tag, ".A"},    16'(A),    active ? 16'(addr) : 16'h0);
        chk({tag, ".DI"},   16'(DI),   (active && we) ? 16'(wd) : 16'h0);
        chk({tag, ".we_n"}, 16'(we_n), (active && access && we) ? 16'h0 : 16'h1);
        chk({tag, ".CS1"},  16'(CS1),  (active && sel != 2'd0) ? 16'h0 : 16'h1);
        chk({tag, ".CS2"},  16'(CS2),  (active && sel == 2'd0) ? 16'h0 : 16'h1);
        chk({tag, ".RS_n"}, 16'(RS_n), (active && sel == 2'd0) ? 16'h0 : 16'h1);
    endtask

    // One transaction. oe_at: WAIT-cycle index where OE rises (-1 = never).
    // hold: cycles rsp_ready stays low in RESP. rst_at: cycle after acceptance
    // at which reset is pulsed (0 = none).
    task automatic run_txn(input bit we, input logic [1:0] sel, input logic [9:0] addr,
                           input logic [7:0] wd, input int oe_at, input logic [7:0] dv,
                           input int hold, input int rst_at);
        int         lat;
        logic [7:0] exp_d;
        bit         exp_e;
        bit         cap;
        if (sel == 2'd3) begin
            lat = 1; exp_d = 8'hFF; exp_e = 1'b1;
        end else if (we) begin
            lat = 2; exp_d = 8'h00; exp_e = 1'b0;
        end else if (sel == 2'd0) begin
            lat = 3; exp_d = dv; exp_e = 1'b0;
        end else if (oe_at >= 0 && oe_at < TO) begin
            lat = 3 + oe_at; exp_d = dv; exp_e = 1'b0;
        end else begin
            lat = 2 + TO; exp_d = 8'hFF; exp_e = 1'b1;
        end

        chk("idle.req_ready", 16'(req_ready), 16'h1);
        req_valid = 1'b1; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wd;
        step();
        for (int k = 1; k < lat; k++) begin
            // stray requests while busy must be ignored
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom);
            req_sel   = 2'($urandom);
            req_addr  = 10'($urandom);
            req_wdata = 8'($urandom);
            cap = (k >= 2) && ((sel == 2'd0 && k == 2) || (sel != 2'd0 && (k - 2) == oe_at));
            DO  = cap ? dv : 8'($urandom);
            if (k == 1 || sel == 2'd0) OE = 1'($urandom_range(0, 1));
            else OE = cap;
            if (rst_at == k) begin
                rst = 1'b1;
                #1;
                chk("rst.rsp_valid", 16'(rsp_valid), 16'h0);
                chk("rst.req_ready", 16'(req_ready), 16'h1);
                chk("rst.rdata", 16'(rsp_rdata), 16'h0);
                chk("rst.err", 16'(rsp_err), 16'h0);
                chk_bus("rst", 1'b0, 1'b0, we, sel, addr, wd);
                req_valid = 1'b0; OE = 1'b0;
                rst = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    step();
                    chk("post_rst.rsp_valid", 16'(rsp_valid), 16'h0);
                    chk("post_rst.req_ready", 16'(req_ready), 16'h1);
                end
                return;
            end
            chk("busy.rsp_valid", 16'(rsp_valid), 16'h0);
            chk("busy.req_ready", 16'(req_ready), 16'h0);
            chk_bus("busy", 1'b1, k == 1, we, sel, addr, wd);
            step();
        end
        req_valid = 1'b0; OE = 1'b0;
        chk("resp.rsp_valid", 16'(rsp_valid), 16'h1);
        chk("resp.req_ready", 16'(req_ready), 16'h0);
        chk("resp.rdata", 16'(rsp_rdata), 16'(exp_d));
        chk("resp.err", 16'(rsp_err), 16'(exp_e));
        chk_bus("resp", 1'b0, 1'b0, we, sel, addr, wd);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            step();
            chk("hold.rsp_valid", 16'(rsp_valid), 16'h1);
            chk("hold.rdata", 16'(rsp_rdata), 16'(exp_d));
            chk("hold.err", 16'(rsp_err), 16'(exp_e));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("done.rsp_valid", 16'(rsp_valid), 16'h0);
        chk("done.req_ready", 16'(req_ready), 16'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pend_seen;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_sel = 2'd0; req_addr = 10'h0;
        req_wdata = 8'h0; rsp_ready = 1'b0; DO = 8'h0; OE = 1'b0; irq_n = 1'b1; irq_ack = 1'b0;
        step();
        step();
        chk("reset.req_ready", 16'(req_ready), 16'h1);
        chk("reset.rsp_valid", 16'(rsp_valid), 16'h0);
        chk("reset.rdata", 16'(rsp_rdata), 16'h0);
        chk("reset.err", 16'(rsp_err), 16'h0);
        chk("reset.irq_pending", 16'(irq_pending), 16'h0);
        chk_bus("reset", 1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 8'h0);
        rst = 1'b0;
        step();

        run_txn(1'b1, 2'd1, 10'h385, 8'h5A, -1, 8'h00, 0, 0);   // RAM write
        run_txn(1'b0, 2'd2, 10'h000, 8'h00, 0, 8'hC3, 0, 0);    // IO read, OE first WAIT
        run_txn(1'b0, 2'd0, 10'h3FF, 8'h00, -1, 8'h4C, 0, 0);   // ROM read, OE ignored
        run_txn(1'b0, 2'd1, 10'h123, 8'h00, -1, 8'h00, 0, 0);   // RAM timeout
        run_txn(1'b0, 2'd1, 10'h0F0, 8'h00, TO - 1, 8'hA7, 0, 0); // capture on last WAIT cycle
        run_txn(1'b0, 2'd2, 10'h0F1, 8'h00, TO, 8'hB8, 0, 0);   // OE one cycle too late
        run_txn(1'b1, 2'd3, 10'h055, 8'h11, -1, 8'h00, 2, 0);   // reserved select
        run_txn(1'b0, 2'd1, 10'h200, 8'h00, -1, 8'h00, 0, 4);   // reset during WAIT
        run_txn(1'b0, 2'd2, 10'h201, 8'h00, 2, 8'h99, 5, 0);    // held response

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), 2'($urandom), 10'($urandom), 8'($urandom),
                    $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, TO)),
                    8'($urandom), $urandom_range(0, 3), 0);
        end

`ifdef RIOT_BUS_MASTER_IRQ_EN
        irq_n = 1'b0;
        pend_seen = 0;
        for (int c = 0; c < 3 && pend_seen == 0; c++) begin
            step();
            if (irq_pending) pend_seen = 1;
        end
        chk("irq.set_within_3", 16'(pend_seen), 16'h1);
        step();
        chk("irq.stays_set", 16'(irq_pending), 16'h1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("irq.ack_clears", 16'(irq_pending), 16'h0);
        irq_n = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("irq.no_rise_set", 16'(irq_pending), 16'h0);
        // ack held across the new edge: the edge must still register
        irq_ack = 1'b1;
        irq_n = 1'b0;
        pend_seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (irq_pending) pend_seen = 1;
        end
        chk("irq.edge_beats_ack", 16'(pend_seen), 16'h1);
        irq_ack = 1'b0;
`else
        irq_n = 1'b0; irq_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            irq_n = ~irq_n;
            chk("irq.disabled", 16'(irq_pending), 16'h0);
        end
        irq_ack = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
